// File: rtl/fpu_reg_stack.sv
// x87-style circular register stack: TOP pointer, per-entry tags, stack-fault detection.
// Optional SAVE/RESTORE streaming is compiled in with `define FPU_STACK_SAVE_EN.
module fpu_reg_stack #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [PTR_W-1:0]   cmd_idx,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic [1:0]         cmd_tag,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic [1:0]         rd_tag,
  output logic               rd_last,
  output logic [PTR_W-1:0]   top,
  output logic [2*DEPTH-1:0] tag_word,
  output logic               stack_fault,
  output logic               c1,
  input  logic               fault_clr
);

  localparam logic [3:0] OP_PUSH    = 4'd1;
  localparam logic [3:0] OP_POP     = 4'd2;
  localparam logic [3:0] OP_WRITE   = 4'd3;
  localparam logic [3:0] OP_READ    = 4'd4;
  localparam logic [3:0] OP_XCH     = 4'd5;
  localparam logic [3:0] OP_FREE    = 4'd6;
  localparam logic [3:0] OP_INIT    = 4'd7;
  localparam logic [3:0] OP_INCSTP  = 4'd8;
  localparam logic [3:0] OP_DECSTP  = 4'd9;
  localparam logic [3:0] OP_READPOP = 4'd10;
  localparam logic [1:0] EMPTY      = 2'b11;

`ifdef FPU_STACK_SAVE_EN
  localparam logic [3:0]       OP_SAVE    = 4'd11;
  localparam logic [3:0]       OP_RESTORE = 4'd12;
  localparam logic [PTR_W-1:0] LAST       = PTR_W'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, XCH2, SAVE, RESTORE} state_t;
`else
  typedef enum logic [0:0] {IDLE, XCH2} state_t;
`endif

  state_t             state;
  logic [WIDTH-1:0]   regs [DEPTH];
  logic [1:0]         tags [DEPTH];
  logic [WIDTH-1:0]   xa_data, xb_data;
  logic [1:0]         xa_tag, xb_tag;
  logic [PTR_W-1:0]   xch_pb;
  logic               xch_ok;
  logic               accept, fault_set, fault_ovf, st0_empty, sti_empty;
  logic [PTR_W-1:0]   p_i, p_dn;
  logic [1:0]         wr_tag;

`ifdef FPU_STACK_SAVE_EN
  logic [PTR_W-1:0]   cnt, p_save;
  assign cmd_ready = (state != XCH2) && (state != SAVE);
  assign p_save    = top + cnt;
`else
  assign cmd_ready = (state == IDLE);
  assign rd_last   = 1'b0;
`endif

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    p_i       = top + cmd_idx;
    p_dn      = top - 1'b1;
    wr_tag    = (cmd_tag == EMPTY) ? 2'b00 : cmd_tag;
    st0_empty = (tags[top] == EMPTY);
    sti_empty = (tags[p_i] == EMPTY);
    for (int p = 0; p < DEPTH; p++) tag_word[2*p +: 2] = tags[p];
  end

  // Fault detection only applies to fresh commands; RESTORE beats never fault.
  always_comb begin
    fault_set = 1'b0;
    fault_ovf = 1'b0;
    if (accept && state == IDLE) begin
      case (cmd_op)
        OP_PUSH: begin
          fault_set = (tags[p_dn] != EMPTY);
          fault_ovf = 1'b1;
        end
        OP_POP, OP_READPOP: fault_set = st0_empty;
        OP_READ:            fault_set = sti_empty;
        OP_XCH:             fault_set = st0_empty || sti_empty;
        default:            fault_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      top         <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_tag      <= EMPTY;
      stack_fault <= 1'b0;
      c1          <= 1'b0;
      xa_data     <= '0;
      xb_data     <= '0;
      xa_tag      <= EMPTY;
      xb_tag      <= EMPTY;
      xch_pb      <= '0;
      xch_ok      <= 1'b0;
      for (int p = 0; p < DEPTH; p++) begin
        regs[p] <= '0;
        tags[p] <= EMPTY;
      end
`ifdef FPU_STACK_SAVE_EN
      rd_last     <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
`ifdef FPU_STACK_SAVE_EN
      rd_last  <= 1'b0;
`endif
      if (fault_set) begin
        stack_fault <= 1'b1;
        c1          <= fault_ovf;
      end else if (fault_clr) begin
        stack_fault <= 1'b0;
        c1          <= 1'b0;
      end

      case (state)
        IDLE: if (accept) begin
          case (cmd_op)
            OP_PUSH: if (!fault_set) begin
              top        <= p_dn;
              regs[p_dn] <= cmd_data;
              tags[p_dn] <= wr_tag;
            end
            OP_POP: if (!fault_set) begin
              tags[top] <= EMPTY;
              top       <= top + 1'b1;
            end
            OP_WRITE: begin
              regs[p_i] <= cmd_data;
              tags[p_i] <= wr_tag;
            end
            OP_READ: begin
              rd_valid <= 1'b1;
              rd_data  <= sti_empty ? '0 : regs[p_i];
              rd_tag   <= tags[p_i];
            end
            OP_READPOP: begin
              rd_valid <= 1'b1;
              rd_data  <= st0_empty ? '0 : regs[top];
              rd_tag   <= tags[top];
              if (!st0_empty) begin
                tags[top] <= EMPTY;
                top       <= top + 1'b1;
              end
            end
            // Snapshot both operands now; the swap is committed in XCH2.
            OP_XCH: begin
              xa_data <= regs[top];
              xa_tag  <= tags[top];
              xb_data <= regs[p_i];
              xb_tag  <= tags[p_i];
              xch_pb  <= p_i;
              xch_ok  <= !fault_set;
              state   <= XCH2;
            end
            OP_FREE:   tags[p_i] <= EMPTY;
            OP_INIT: begin
              top         <= '0;
              stack_fault <= 1'b0;
              c1          <= 1'b0;
              for (int p = 0; p < DEPTH; p++) tags[p] <= EMPTY;
            end
            OP_INCSTP: top <= top + 1'b1;
            OP_DECSTP: top <= top - 1'b1;
`ifdef FPU_STACK_SAVE_EN
            OP_SAVE: begin
              cnt   <= '0;
              state <= SAVE;
            end
            OP_RESTORE: begin
              cnt   <= '0;
              state <= RESTORE;
            end
`endif
            default: ;
          endcase
        end
        XCH2: begin
          if (xch_ok) begin
            regs[top]    <= xb_data;
            tags[top]    <= xb_tag;
            regs[xch_pb] <= xa_data;
            tags[xch_pb] <= xa_tag;
          end
          state <= IDLE;
        end
`ifdef FPU_STACK_SAVE_EN
        SAVE: begin
          rd_valid <= 1'b1;
          rd_data  <= regs[p_save];
          rd_tag   <= tags[p_save];
          rd_last  <= (cnt == LAST);
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) state <= IDLE;
        end
        RESTORE: if (accept) begin
          regs[p_save] <= cmd_data;
          tags[p_save] <= wr_tag;
          cnt          <= cnt + 1'b1;
          if (cnt == LAST) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
